nfca_rx_frame_buffer: RTL and testbench

// - Sits directly downstream of the NFC-A controller's RX byte stream (rx_tvalid/rx_tdata/rx_tdatab/rx_tend/rx_terr).
// - Collects one PICC-to-PCD frame into a byte buffer and checks CRC_A on the fly.
// - Replays the frame on an AXI-stream-like master port with backpressure, and presents per-frame status.

---
 rtl/nfca_rx_frame_buffer_pkg.sv | 13 +
 rtl/nfca_crc_a.sv | 20 ++
 rtl/nfca_rx_frame_buffer.sv | 128 ++++++++++++
 tb/tb_nfca_rx_frame_buffer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/nfca_rx_frame_buffer_pkg.sv
// rtl/nfca_rx_frame_buffer_pkg.sv - shared constants and types for the NFC-A RX frame buffer
package nfca_rx_frame_buffer_pkg;

  localparam logic [15:0] CRC_A_INIT = 16'h6363;
  localparam logic [15:0] CRC_A_POLY = 16'h8408;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/nfca_crc_a.sv
// rtl/nfca_crc_a.sv - combinational CRC_A single-byte step (reflected, LSB first)
module nfca_crc_a
  import nfca_rx_frame_buffer_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_A_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/nfca_rx_frame_buffer.sv
// rtl/nfca_rx_frame_buffer.sv - captures one NFC-A RX frame, checks CRC_A, replays it on a stream port
module nfca_rx_frame_buffer
  import nfca_rx_frame_buffer_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int LEN_W = $clog2(DEPTH + 1)
) (
  input  logic             rstn,
  input  logic             clk,
  input  logic             rx_on,
  input  logic             rx_tvalid,
  input  logic [7:0]       rx_tdata,
  input  logic [3:0]       rx_tdatab,
  input  logic             rx_tend,
  input  logic             rx_terr,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [7:0]       m_tdata,
  output logic [3:0]       m_tdatab,
  output logic             m_tlast,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_crc_ok,
  output logic             frame_err,
  output logic             frame_ovf,
  output logic [7:0]       drop_cnt
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           state;
  logic [7:0]       mem [DEPTH];
  logic [LEN_W-1:0] wr_ptr, rd_ptr;
  logic [15:0]      crc;
  logic             all_full, ovf, rx_on_q;
  logic [3:0]       last_datab;

  logic             idle, take, store, rx_fall, close, drop;
  logic [LEN_W-1:0] base_wr, wr_nxt;
  logic [15:0]      base_crc, crc_step, crc_nxt;
  logic             base_full, full_nxt, base_ovf, ovf_nxt;
  logic [3:0]       datab_nxt;

  nfca_crc_a u_crc (
    .crc_in  (base_crc),
    .data    (rx_tdata),
    .crc_out (crc_step)
  );

  // In IDLE the first byte starts from a fresh accumulator, so the same
  // next-value path serves both frame start and the middle of a frame.
  always_comb begin
    idle      = (state == ST_IDLE);
    base_wr   = idle ? '0 : wr_ptr;
    base_crc  = idle ? CRC_A_INIT : crc;
    base_full = idle ? 1'b1 : all_full;
    base_ovf  = idle ? 1'b0 : ovf;
    take      = rx_tvalid & (idle | (state == ST_RECV));
    store     = take & (base_wr < LEN_W'(DEPTH));
    wr_nxt    = store ? base_wr + LEN_W'(1) : base_wr;
    crc_nxt   = (store && rx_tdatab == 4'd8) ? crc_step : base_crc;
    full_nxt  = base_full & ~(store & (rx_tdatab != 4'd8));
    ovf_nxt   = base_ovf | (take & ~store);
    datab_nxt = store ? rx_tdatab : last_datab;
    rx_fall   = rx_on_q & ~rx_on;
    close     = (rx_tend | rx_fall) & ((state == ST_RECV) | (idle & rx_tvalid));
    drop      = rx_tend & ((idle & ~rx_tvalid) | (state == ST_DRAIN));
  end

  always_ff @(posedge clk) begin
    if (store) mem[base_wr[ADDR_W-1:0]] <= rx_tdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      crc          <= CRC_A_INIT;
      all_full     <= 1'b0;
      ovf          <= 1'b0;
      last_datab   <= '0;
      rx_on_q      <= 1'b0;
      m_tvalid     <= 1'b0;
      frame_len    <= '0;
      frame_crc_ok <= 1'b0;
      frame_err    <= 1'b0;
      frame_ovf    <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      rx_on_q <= rx_on;
      if (take) begin
        wr_ptr     <= wr_nxt;
        crc        <= crc_nxt;
        all_full   <= full_nxt;
        ovf        <= ovf_nxt;
        last_datab <= datab_nxt;
      end
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;

      if (idle && rx_tvalid) begin
        state <= ST_RECV;
      end else if (state == ST_DRAIN && m_tvalid && m_tready) begin
        if (m_tlast) begin
          m_tvalid <= 1'b0;
          state    <= ST_IDLE;
        end else begin
          rd_ptr <= rd_ptr + LEN_W'(1);
        end
      end

      // Close wins over the IDLE->RECV step when a one-byte frame ends at once.
      if (close) begin
        state        <= ST_DRAIN;
        m_tvalid     <= 1'b1;
        rd_ptr       <= '0;
        frame_len    <= wr_nxt;
        frame_crc_ok <= (wr_nxt >= LEN_W'(3)) && (crc_nxt == 16'h0000) && full_nxt && !ovf_nxt;
        frame_err    <= (rx_tend & rx_terr) | rx_fall;
        frame_ovf    <= ovf_nxt;
      end
    end
  end

  assign m_tlast  = m_tvalid && (rd_ptr == frame_len - LEN_W'(1));
  assign m_tdata  = m_tvalid ? mem[rd_ptr[ADDR_W-1:0]] : 8'h00;
  assign m_tdatab = m_tvalid ? (m_tlast ? last_datab : 4'd8) : 4'd0;

endmodule

// File: tb/tb_nfca_rx_frame_buffer.sv
// tb/tb_nfca_rx_frame_buffer.sv - self-checking bench for nfca_rx_frame_buffer
module tb_nfca_rx_frame_buffer;

  localparam int DEPTH = 64;
  localparam int LEN_W = $clog2(DEPTH + 1);

  logic             rstn, clk, rx_on, rx_tvalid, rx_tend, rx_terr;
  logic [7:0]       rx_tdata;
  logic [3:0]       rx_tdatab;
  logic             m_tvalid, m_tready, m_tlast;
  logic [7:0]       m_tdata;
  logic [3:0]       m_tdatab;
  logic [LEN_W-1:0] frame_len;
  logic             frame_crc_ok, frame_err, frame_ovf;
  logic [7:0]       drop_cnt;

  int n_vec = 0;
  int n_bad = 0;
  int exp_drop = 0;

  nfca_rx_frame_buffer #(.DEPTH(DEPTH)) dut (
    .rstn(rstn), .clk(clk), .rx_on(rx_on), .rx_tvalid(rx_tvalid), .rx_tdata(rx_tdata),
    .rx_tdatab(rx_tdatab), .rx_tend(rx_tend), .rx_terr(rx_terr), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tdata(m_tdata), .m_tdatab(m_tdatab), .m_tlast(m_tlast),
    .frame_len(frame_len), .frame_crc_ok(frame_crc_ok), .frame_err(frame_err),
    .frame_ovf(frame_ovf), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b [4];
    int         n;
    int         last_bits;
    bit         terr;
    bit         tend_last;
    int         exp_len;
    bit         exp_crc;
    bit         exp_err;
  } vec_t;

  vec_t tbl [8];

  function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, input int n, lb,
                              input bit terr, tl, input int el, input bit ec, ee);
    vec_t v;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.n = n; v.last_bits = lb; v.terr = terr; v.tend_last = tl;
    v.exp_len = el; v.exp_crc = ec; v.exp_err = ee;
    return v;
  endfunction

  // Byte-wise CRC_A as published for ISO/IEC 14443-3 (nibble-folding form).
  function automatic logic [15:0] crc_model(input logic [7:0] q[$]);
    logic [15:0] c;
    logic [7:0]  ch;
    c = 16'h6363;
    foreach (q[i]) begin
      ch = q[i] ^ c[7:0];
      ch = ch ^ (ch << 4);
      c  = (c >> 8) ^ ({8'h00, ch} << 8) ^ ({8'h00, ch} << 3) ^ ({8'h00, ch} >> 4);
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    exp_drop = 0;
  endtask

  task automatic send_frame(input logic [7:0] q[$], input int last_bits, input bit terr,
                            input bit tend_last, input bit no_end, input bit gaps);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      rx_tvalid = 1'b1;
      rx_tdata  = q[i];
      rx_tdatab = (i == q.size() - 1) ? 4'(last_bits) : 4'd8;
      rx_tend   = tend_last && (i == q.size() - 1);
      rx_terr   = rx_tend & terr;
      @(negedge clk);
      rx_tvalid = 1'b0; rx_tend = 1'b0; rx_terr = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    if (!tend_last && !no_end) begin
      rx_tend = 1'b1;
      rx_terr = terr;
      @(negedge clk);
      rx_tend = 1'b0;
      rx_terr = 1'b0;
    end
  endtask

  // Pulls the buffered frame out under random backpressure and compares every
  // presented beat; status must hold for the whole drain.
  task automatic drain_check(input string tag, input logic [7:0] q[$], input int last_bits,
                             input int exp_len, input bit exp_crc, input bit exp_err,
                             input bit exp_ovf, input int ready_pct);
    int idx = 0;
    int cycles = 0;
    int n = q.size();
    while (idx < n && cycles < 4000) begin
      @(negedge clk);
      cycles++;
      m_tready = ($urandom_range(0, 99) < ready_pct);
      if (m_tvalid) begin
        chk({tag, "_data"}, m_tdata, q[idx]);
        chk({tag, "_last"}, m_tlast, (idx == n - 1));
        chk({tag, "_datab"}, m_tdatab, (idx == n - 1) ? last_bits : 8);
        if (m_tready) begin
          chk({tag, "_len"}, frame_len, exp_len);
          chk({tag, "_crc_ok"}, frame_crc_ok, exp_crc);
          chk({tag, "_err"}, frame_err, exp_err);
          chk({tag, "_ovf"}, frame_ovf, exp_ovf);
          idx++;
        end
      end
    end
    chk({tag, "_beats"}, idx, n);
    @(negedge clk);
    m_tready = 1'b0;
    chk({tag, "_idle_after"}, m_tvalid, 0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] qa[$];
    rx_on = 1'b1; rx_tvalid = 1'b0; rx_tdata = '0; rx_tdatab = 4'd8;
    rx_tend = 1'b0; rx_terr = 1'b0; m_tready = 1'b0;
    do_reset();

    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_len", frame_len, 0);
    chk("rst_flags", {frame_crc_ok, frame_err, frame_ovf}, 0);
    chk("rst_drop", drop_cnt, 0);

    tbl[0] = mk(8'h44, 8'h00, 8'h00, 8'h00, 2, 8, 0, 0, 2, 0, 0);
    tbl[1] = mk(8'h08, 8'hB6, 8'hDD, 8'h00, 3, 8, 0, 0, 3, 1, 0);
    tbl[2] = mk(8'h08, 8'hB6, 8'hDC, 8'h00, 3, 8, 0, 0, 3, 0, 0);
    tbl[3] = mk(8'h93, 8'h20, 8'h00, 8'h00, 2, 7, 0, 0, 2, 0, 0);
    tbl[4] = mk(8'h08, 8'hB6, 8'hDD, 8'h00, 3, 8, 0, 1, 3, 1, 0);
    tbl[5] = mk(8'h08, 8'hB6, 8'hDD, 8'h00, 3, 8, 1, 0, 3, 1, 1);
    tbl[6] = mk(8'h52, 8'h00, 8'h00, 8'h00, 1, 8, 0, 0, 1, 0, 0);
    tbl[7] = mk(8'h26, 8'h00, 8'h00, 8'h00, 1, 7, 0, 1, 1, 0, 0);

    for (int t = 0; t < 8; t++) begin
      q = {};
      for (int i = 0; i < tbl[t].n; i++) q.push_back(tbl[t].b[i]);
      send_frame(q, tbl[t].last_bits, tbl[t].terr, tbl[t].tend_last, 0, 0);
      drain_check($sformatf("tbl%0d", t), q, tbl[t].last_bits, tbl[t].exp_len,
                  tbl[t].exp_crc, tbl[t].exp_err, 0, 50);
    end

    // Overflow: only the first DEPTH bytes are kept.
    q = {};
    for (int i = 0; i < DEPTH + 2; i++) q.push_back(8'($urandom));
    send_frame(q, 8, 0, 0, 0, 0);
    qa = q[0:DEPTH-1];
    drain_check("ovf", qa, 8, DEPTH, 0, 0, 1, 70);

    // Zero-length frame in IDLE is a drop.
    @(negedge clk); rx_tend = 1'b1;
    @(negedge clk); rx_tend = 1'b0;
    exp_drop++;
    chk("drop_zero_len", drop_cnt, exp_drop);

    // Second frame arriving while the first is still held.
    qa = {8'h08, 8'hB6, 8'hDD};
    send_frame(qa, 8, 0, 0, 0, 0);
    chk("drop_hold_valid", m_tvalid, 1);
    q = {8'h44, 8'h00};
    send_frame(q, 8, 0, 0, 0, 0);
    exp_drop++;
    chk("drop_during_drain", drop_cnt, exp_drop);
    drain_check("first_intact", qa, 8, 3, 1, 0, 0, 50);

    // rx_on falling mid-frame truncates with an error.
    q = {8'h11, 8'h22};
    send_frame(q, 8, 0, 0, 1, 0);
    rx_on = 1'b0;
    @(negedge clk);
    rx_on = 1'b1;
    drain_check("rx_on_fall", q, 8, 2, 0, 1, 0, 50);

    // Random frames against the model; half carry a valid appended CRC.
    for (int f = 0; f < 20; f++) begin
      int lb;
      bit terr, full;
      logic [15:0] c;
      q = {};
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < $urandom_range(1, 6); i++) q.push_back(8'($urandom));
        c = crc_model(q);
        q.push_back(c[7:0]);
        q.push_back(c[15:8]);
        lb = 8;
      end else begin
        for (int i = 0; i < $urandom_range(1, 10); i++) q.push_back(8'($urandom));
        lb = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 8;
      end
      terr = ($urandom_range(0, 4) == 0);
      full = (lb == 8);
      send_frame(q, lb, terr, $urandom_range(0, 1), 0, 1);
      drain_check($sformatf("rnd%0d", f), q, lb, q.size(),
                  (q.size() >= 3) && full && (crc_model(q) == 16'h0000), terr, 0, 40);
    end
    chk("drop_after_random", drop_cnt, exp_drop);

    // Reset in the middle of a drain.
    q = {8'hAA, 8'h55, 8'h5A};
    send_frame(q, 8, 0, 0, 0, 0);
    chk("pre_rst_valid", m_tvalid, 1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst_mid_tvalid", m_tvalid, 0);
    chk("rst_mid_drop", drop_cnt, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_no_output", m_tvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
